// File: rtl/int_to_fpu_conv.sv
// int_to_fpu_conv
// Converts a 32-bit two's-complement integer into the FPU float word
// {sign[31], exp[30:25], mant[24:0]}. The word has a hidden leading 1 and a
// biased exponent: value = (-1)^s * 1.mant * 2^(exp-BIAS).
// Normalisation shifts one bit per clock, under a start/busy/done handshake.
//
// Parameters:
//   BIAS        exponent bias, 0..32 (default 31)
// Ports:
//   clock100KHz system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       conversion request, sampled only while idle
//   int_in      signed integer, captured on the edge that accepts start
//   busy        high from the accepting edge until the pack edge completes
//   done        one-cycle pulse; data_out/status_out are valid from this cycle
//   data_out    encoded float {sign, exp6, mant25}
//   status_out  one-hot: 0001 exact, 0010 inexact, 0100 overflow,
//               1000 underflow (never raised)
// Build option:
//   ROUND_NEAREST_EVEN_EN  when defined, rounding is ties-to-even instead of
//                          round half-up.

module int_to_fpu_conv #(
    parameter int unsigned BIAS = 31
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        NORM,
        ROUND,
        PACK
    } state_t;

    localparam logic [6:0] EXP_INIT = 7'(BIAS + 31);

    localparam logic [3:0] ST_EXACT    = 4'b0001;
    localparam logic [3:0] ST_INEXACT  = 4'b0010;
    localparam logic [3:0] ST_OVERFLOW = 4'b0100;

    state_t      state;
    state_t      state_nxt;

    // mag holds the raw captured integer in ABS, then the magnitude
    logic [31:0] mag;
    logic [6:0]  exp7;
    logic [24:0] mant;
    logic        sign;
    logic        inexact;
    logic        is_zero;

    logic        guard;
    logic        sticky;
    logic        rnd_inc;
    logic [25:0] mant_sum;

    // Rounding of the normalised magnitude; 26-bit sum exposes the carry
    always_comb begin
        guard  = mag[5];
        sticky = |mag[4:0];
`ifdef ROUND_NEAREST_EVEN_EN
        rnd_inc = guard & (sticky | mag[6]);
`else
        rnd_inc = guard;
`endif
        mant_sum = {1'b0, mag[30:6]} + {25'd0, rnd_inc};
    end

    // State register
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ABS;
            ABS:     state_nxt = (mag == '0) ? PACK : NORM;
            NORM:    if (mag[31]) state_nxt = ROUND;
            ROUND:   state_nxt = PACK;
            PACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath and registered results
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            mag        <= '0;
            exp7       <= '0;
            mant       <= '0;
            sign       <= 1'b0;
            inexact    <= 1'b0;
            is_zero    <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag <= int_in;
                    end
                end
                ABS: begin
                    // Negating 0x80000000 yields 0x80000000, the correct
                    // unsigned magnitude.
                    sign    <= mag[31];
                    mag     <= mag[31] ? (~mag + 32'd1) : mag;
                    exp7    <= EXP_INIT;
                    is_zero <= (mag == '0);
                    inexact <= 1'b0;
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag  <= {mag[30:0], 1'b0};
                        exp7 <= exp7 - 7'd1;
                    end
                end
                ROUND: begin
                    mant    <= mant_sum[24:0];
                    inexact <= guard | sticky;
                    if (mant_sum[25]) begin
                        exp7 <= exp7 + 7'd1;
                    end
                end
                PACK: begin
                    // Overflow is tested first, ahead of the zero case
                    if (exp7 >= 7'd63) begin
                        data_out   <= '0;
                        status_out <= ST_OVERFLOW;
                    end else if (is_zero) begin
                        data_out   <= '0;
                        status_out <= ST_EXACT;
                    end else begin
                        data_out   <= {sign, exp7[5:0], mant};
                        status_out <= inexact ? ST_INEXACT : ST_EXACT;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fpu_conv.sv
`timescale 1ns/1ps

module tb_int_to_fpu_conv;

    logic        clock100KHz = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [31:0] in_a, in_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  status_a, status_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock100KHz = ~clock100KHz;

    int_to_fpu_conv #(.BIAS(31)) dut (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .start       (start_a),
        .int_in      (in_a),
        .busy        (busy_a),
        .done        (done_a),
        .data_out    (data_a),
        .status_out  (status_a)
    );

    int_to_fpu_conv #(.BIAS(32)) dut32 (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .start       (start_b),
        .int_in      (in_b),
        .busy        (busy_b),
        .done        (done_b),
        .data_out    (data_b),
        .status_out  (status_b)
    );

    // Value-level reference: exact magnitude, leading-one position,
    // rounding of the discarded remainder.
    function automatic void ref_model(input logic [31:0] x, input int bias,
                                      output logic [31:0] d, output logic [3:0] st,
                                      output int lat);
        longint xl, mag, q, rem, half;
        int     p, e, shift;
        bit     inex, up;
        logic [5:0]  ef;
        logic [24:0] mf;
        xl = longint'({32'd0, x});
        if (x == 32'd0) begin
            lat = 2;
            d   = 32'd0;
            st  = (bias + 31 >= 63) ? 4'b0100 : 4'b0001;
            return;
        end
        mag = x[31] ? (64'h1_0000_0000 - xl) : xl;
        p = 0;
        for (int i = 0; i < 32; i++)
            if (((mag >> i) & 64'd1) == 64'd1) p = i;
        lat  = 4 + 31 - p;
        inex = 1'b0;
        if (p <= 25) begin
            q = mag << (25 - p);
        end else begin
            shift = p - 25;
            q     = mag >> shift;
            rem   = mag - (q << shift);
            half  = 64'd1 << (shift - 1);
            inex  = (rem != 0);
`ifdef ROUND_NEAREST_EVEN_EN
            up = (rem > half) || (rem == half && (q & 64'd1) == 64'd1);
`else
            up = (rem >= half);
`endif
            if (up) q = q + 1;
        end
        e = p;
        if (q == (64'd1 << 26)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (bias + e >= 63) begin
            d  = 32'd0;
            st = 4'b0100;
        end else begin
            ef = 6'(bias + e);
            mf = 25'(q - (64'd1 << 25));
            d  = {x[31], ef, mf};
            st = inex ? 4'b0010 : 4'b0001;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock100KHz);
        #1;
    endtask

    // Drives start for one edge; returns 1 time unit after the accepting edge
    task automatic issue(input bit sel, input logic [31:0] x);
        if (sel) begin start_b = 1'b1; in_b = x; end
        else     begin start_a = 1'b1; in_a = x; end
        @(posedge clock100KHz);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check("busy_after_accept", 32'(sel ? busy_b : busy_a), 32'd1);
        check("done_low_after_accept", 32'(sel ? done_b : done_a), 32'd0);
    endtask

    // Waits for done (bounded), checking latency and results. With poke set,
    // a second start is offered mid-conversion and must be ignored.
    task automatic finish(input bit sel, input logic [31:0] exp_d, input logic [3:0] exp_s,
                          input int exp_lat, input bit poke);
        int cnt;
        cnt = 0;
        while (!(sel ? done_b : done_a) && cnt < 100) begin
            @(posedge clock100KHz);
            #1;
            cnt++;
            if (poke && cnt == 5) begin
                if (sel) begin start_b = 1'b1; in_b = 32'hDEADBEEF; end
                else     begin start_a = 1'b1; in_a = 32'hDEADBEEF; end
            end
            if (poke && cnt == 8) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        check("latency", 32'(cnt), 32'(exp_lat));
        check("data_out", sel ? data_b : data_a, exp_d);
        check("status_out", {28'd0, (sel ? status_b : status_a)}, {28'd0, exp_s});
        check("busy_at_done", 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    initial begin
        logic [31:0] x, d;
        logic [3:0]  s;
        int          l;
        bit          saw_done;

        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        in_a    = '0;
        in_b    = '0;
        idle(3);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_done", 32'(done_a), 32'd0);
        check("reset_data", data_a, 32'd0);
        check("reset_status", {28'd0, status_a}, 32'd0);
        check("reset_data_b32", data_b, 32'd0);
        reset = 1'b1;
        idle(2);

        // Directed, BIAS=31
        issue(0, 32'h0000_0001);
        finish(0, 32'h3E00_0000, 4'b0001, 35, 1'b1);
        idle(1);
        issue(0, 32'hFFFF_FFFA);
        finish(0, 32'hC300_0000, 4'b0001, 33, 1'b0);
        issue(0, 32'h0000_0000);                       // back-to-back
        finish(0, 32'h0000_0000, 4'b0001, 2, 1'b0);
        issue(0, 32'h8000_0000);                       // back-to-back
        finish(0, 32'hFC00_0000, 4'b0001, 4, 1'b0);
        idle(1);
        issue(0, 32'h7FFF_FFFF);
        finish(0, 32'h7C00_0000, 4'b0010, 5, 1'b0);
        idle(1);
        issue(0, 32'h0400_0001);
`ifdef ROUND_NEAREST_EVEN_EN
        finish(0, 32'h7200_0000, 4'b0010, 9, 1'b0);
`else
        finish(0, 32'h7200_0001, 4'b0010, 9, 1'b0);
`endif

        // Directed, BIAS=32
        idle(1);
        issue(1, 32'h8000_0000);
        finish(1, 32'h0000_0000, 4'b0100, 4, 1'b0);
        idle(1);
        issue(1, 32'h0000_0001);
        finish(1, 32'h4000_0000, 4'b0001, 35, 1'b0);
        idle(1);
        issue(1, 32'h7FFF_FFFF);
        finish(1, 32'h0000_0000, 4'b0100, 5, 1'b0);

        // Reset in the middle of a conversion
        idle(1);
        issue(0, 32'h0000_0001);
        idle(10);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_data", data_a, 32'd0);
        check("abort_status", {28'd0, status_a}, 32'd0);
        idle(2);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clock100KHz);
            #1;
            if (done_a) saw_done = 1'b1;
        end
        check("no_done_after_abort", 32'(saw_done), 32'd0);
        issue(0, 32'h0000_0010);
        finish(0, 32'h4600_0000, 4'b0001, 31, 1'b0);

        // Randomised against the reference model
        for (int i = 0; i < 40; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
            if (i % 7 == 3) x = 32'd0;
            ref_model(x, 31, d, s, l);
            issue(0, x);
            finish(0, d, s, l, 1'b0);
            if (i % 2 == 1) idle(1);
        end
        for (int i = 0; i < 12; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
            if (x == 32'd0) x = 32'h8000_0000;
            ref_model(x, 32, d, s, l);
            issue(1, x);
            finish(1, d, s, l, 1'b0);
            if (i % 2 == 1) idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
